ob_cn_issue_arb: RTL and testbench
==================================

# ob_cn_issue_arb

Merges matured conditional commands with fresh ingress commands into the single command stream that feeds the order-book controller. It sits directly downstream of the conditional table's maturity interface. A small FIFO decouples maturity from issue. A registered output stage uses a valid/accept handshake, and a bounded-priority arbiter favours matured commands without starving ingress.

## Interface
- `D`, 4: matured-command FIFO depth; power of two, ≥2.
- `STARVE_N`, 4: consecutive matured wins allowed while ingress waits; ≥1.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low (`rst`=0 resets).
- `mtr_vld_r`  in  1  matured command valid, from conditional table.
- `mtr_r`  in  `ob_pkg::cmd_t`  matured command.
- `mtr_accept`  out  1  matured command taken this cycle.
- `ing_vld`  in  1  ingress command valid.
- `ing_cmd`  in  `ob_pkg::cmd_t`  ingress command.
- `ing_accept`  out  1  ingress command taken this cycle.
- `iss_vld_r`  out  1  issue valid to controller (registered).
- `iss_r`  out  `ob_pkg::cmd_t`  issued command (registered).
- `iss_accept`  in  1  controller consumes `iss_r`.
- `fifo_cnt_r`  out  `$clog2(D+1)`  FIFO occupancy.
- `fifo_full_r`  out  1  occupancy == `D`.

## Operation
- FIFO push: `mtr_accept = ~fifo_full_r`. Push when `mtr_vld_r & mtr_accept`.
- No push while full, even if a pop occurs in the same cycle.
- Output stage enable: `iss_en = ~iss_vld_r | iss_accept`. The output holds `iss_r` stable until accepted.
- Candidates when `iss_en`=1:
  - F: FIFO head, valid when `fifo_cnt_r != 0`.
  - I: ingress, valid when `ing_vld`.
- Selection:
  - F only: F.
  - I only: I.
  - Both present: F, unless `starve_cnt_r == STARVE_N`, in which case I.
  - Neither present: `iss_vld_r` loads 0.
- Pop is F selected with `iss_en`. `ing_accept` is I selected with `iss_en`; it is combinational and never asserted without `ing_vld`.
- `starve_cnt_r` (internal, width `$clog2(STARVE_N+1)`):
  - F wins while `ing_vld`=1: increment, saturating at `STARVE_N`.
  - I wins, or `ing_vld`=0: clear to 0.
  - Otherwise: hold.
- FIFO storage: circular buffer with wrapping read and write pointers of width `$clog2(D)`. Occupancy is tracked in a separate counter.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Command ordering: matured commands leave in maturity order. Ingress order is preserved.

## Timing
- Reset values:
  - `iss_vld_r`=0, `iss_r`='0.
  - `fifo_cnt_r`=0, `fifo_full_r`=0, pointers 0, `starve_cnt_r`=0.
  - During reset: `mtr_accept`=1, `ing_accept`=0.
- Matured latency: pushed at cycle t, at FIFO head at t+1, in `iss_r` at t+2 (best case).
- Ingress latency: accepted at cycle t, in `iss_r` at t+1.
- There is no FIFO bypass.
- Sustained throughput is one command per cycle when `iss_accept` is held at 1.
- Reset asserted mid-operation discards all FIFO contents and any pending `iss_r` immediately. No command is issued twice after release.
- A full FIFO deasserts `mtr_accept` in the same cycle `fifo_full_r` rises, with no combinational path from `iss_accept` to `mtr_accept`.

## Structure
- `ob_pkg` provides `cmd_t` (existing).
- Add `ob_pkg` constants `CN_ISSUE_FIFO_D` and `CN_ISSUE_STARVE_N` as the instantiation defaults.
- Sub-module `ob_cn_issue_fifo`: parameters `D` and `W`. Ports: push/data, pop, head, count, full. Asynchronous active-low reset on control state only.
- Arbiter, starvation counter and output register live in `ob_cn_issue_arb`.

## Test plan
- Reset, then a single matured command A with `iss_accept`=1:
  - `mtr_accept`=1 at t.
  - `iss_vld_r`=1 with `iss_r`=A at t+2, then 0 at t+3.
- Four matured commands pushed back-to-back with `D`=4 and `iss_accept`=0:
  - `fifo_full_r`=1 after the fourth push; `mtr_accept`=0 after the fourth push.
  - A fifth command is held upstream.
  - Raising `iss_accept` drains them in order, one per cycle.
- FIFO is kept non-empty and `ing_vld`=1 throughout, `STARVE_N`=4:
  - Issue sequence is F,F,F,F,I,F,F,F,F,I.
  - `ing_accept` pulses exactly on each I slot.
- `iss_accept`=0 for 5 cycles with `iss_vld_r`=1:
  - `iss_r` stays constant.
  - `ing_accept`=0 and no FIFO pop.
  - FIFO still accepts pushes until full.
- Simultaneous push and pop at occupancy 2:
  - Occupancy stays 2.
  - Pointers wrap correctly across index `D-1`→0.
  - Order is preserved.
- Reset pulsed while the FIFO holds 3 entries and `iss_vld_r`=1:
  - All outputs return to their reset values asynchronously.
  - After release, no stale command is issued.

Source files
------------

// File: rtl/ob_cn_issue_arb_pkg.sv
// Source-selection type and decision helper for the conditional issue arbiter.
package ob_cn_issue_arb_pkg;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_FIFO = 2'd1,
        SEL_ING  = 2'd2
    } sel_e;

    // Matured commands win ties unless ingress has waited the full starvation budget.
    function automatic sel_e pick_src(input logic en, input logic f_vld,
                                      input logic i_vld, input logic starved);
        sel_e s;
        s = SEL_NONE;
        if (en) begin
            if (f_vld && i_vld) s = starved ? SEL_ING : SEL_FIFO;
            else if (f_vld)     s = SEL_FIFO;
            else if (i_vld)     s = SEL_ING;
        end
        return s;
    endfunction

endpackage

// File: rtl/ob_pkg.sv
// Shared order-book types and the default sizing of the conditional issue arbiter.
package ob_pkg;

    // Order-book command, as produced by ingress and by the conditional table.
    typedef struct packed {
        logic [7:0]  id;
        logic        side;
        logic [1:0]  op;
        logic [15:0] price;
        logic [4:0]  qty;
    } cmd_t;

    // Instantiation defaults for ob_cn_issue_arb.
    localparam int CN_ISSUE_FIFO_D    = 4;
    localparam int CN_ISSUE_STARVE_N  = 4;

endpackage

// File: rtl/ob_cn_issue_arb_if.sv
// Handshake bundle between the conditional table / ingress / controller and the issue arbiter.
interface ob_cn_issue_arb_if import ob_pkg::*; #(
    parameter int D = CN_ISSUE_FIFO_D
);
    localparam int CW = $clog2(D + 1);

    logic          mtr_vld_r;
    cmd_t          mtr_r;
    logic          mtr_accept;
    logic          ing_vld;
    cmd_t          ing_cmd;
    logic          ing_accept;
    logic          iss_vld_r;
    cmd_t          iss_r;
    logic          iss_accept;
    logic [CW-1:0] fifo_cnt_r;
    logic          fifo_full_r;

    // Environment side: drives commands in and consumes the issue stream.
    modport master (
        output mtr_vld_r, mtr_r, ing_vld, ing_cmd, iss_accept,
        input  mtr_accept, ing_accept, iss_vld_r, iss_r, fifo_cnt_r, fifo_full_r
    );

    // Arbiter side.
    modport slave (
        input  mtr_vld_r, mtr_r, ing_vld, ing_cmd, iss_accept,
        output mtr_accept, ing_accept, iss_vld_r, iss_r, fifo_cnt_r, fifo_full_r
    );
endinterface

// File: rtl/ob_cn_issue_fifo.sv
// Circular-buffer FIFO for matured commands; pointers wrap, occupancy kept in its own counter.
module ob_cn_issue_fifo #(
    parameter int D = 4,
    parameter int W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(D+1)-1:0]   cnt_o,
    output logic                     full_o
);
    localparam int PW = $clog2(D);
    localparam int CW = $clog2(D + 1);

    logic [W-1:0]  mem_q [D];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          do_push, do_pop;

    // A pop freeing a slot does not open it for a push in the same cycle.
    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & (cnt_q != '0);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + PW'(1);
        if (do_pop)  rd_d = rd_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d = (cnt_d == CW'(D));
    end

    // Control state; reset drops all contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    // Storage needs no reset: occupancy decides what is live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

    assign head_o = mem_q[rd_q];
    assign cnt_o  = cnt_q;
    assign full_o = full_q;

endmodule

// File: rtl/ob_cn_issue_arb.sv
// Merges matured conditional commands (via FIFO) with ingress into one registered issue stream.
module ob_cn_issue_arb import ob_pkg::*, ob_cn_issue_arb_pkg::*; #(
    parameter int D        = CN_ISSUE_FIFO_D,
    parameter int STARVE_N = CN_ISSUE_STARVE_N
) (
    input  logic             clk,
    input  logic             rst,
    ob_cn_issue_arb_if.slave bus
);
    localparam int CW = $clog2(D + 1);
    localparam int SW = $clog2(STARVE_N + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_N);

    logic          iss_vld_q, iss_vld_d;
    cmd_t          iss_q, iss_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full;
    cmd_t          fifo_head;
    logic          iss_en;
    sel_e          sel;

    ob_cn_issue_fifo #(
        .D (D),
        .W ($bits(cmd_t))
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (bus.mtr_vld_r & ~fifo_full),
        .push_data_i (bus.mtr_r),
        .pop_i       (sel == SEL_FIFO),
        .head_o      (fifo_head),
        .cnt_o       (fifo_cnt),
        .full_o      (fifo_full)
    );

    // Output register can take a new command when empty or being consumed.
    assign iss_en = ~iss_vld_q | bus.iss_accept;
    assign sel    = pick_src(iss_en, fifo_cnt != '0, bus.ing_vld, starve_q == STARVE_MAX);

    // mtr_accept depends only on registered full, so iss_accept never reaches it.
    assign bus.mtr_accept  = ~fifo_full;
    // Held low through reset so ingress cannot be consumed while the stage is cleared.
    assign bus.ing_accept  = rst & (sel == SEL_ING);
    assign bus.iss_vld_r   = iss_vld_q;
    assign bus.iss_r       = iss_q;
    assign bus.fifo_cnt_r  = fifo_cnt;
    assign bus.fifo_full_r = fifo_full;

    // Output stage load and starvation bookkeeping.
    always_comb begin
        iss_vld_d = iss_vld_q;
        iss_d     = iss_q;
        starve_d  = starve_q;
        if (iss_en) begin
            iss_vld_d = (sel != SEL_NONE);
            if (sel == SEL_FIFO)     iss_d = fifo_head;
            else if (sel == SEL_ING) iss_d = bus.ing_cmd;
        end
        if (sel == SEL_FIFO && bus.ing_vld) begin
            if (starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);
        end else if (sel == SEL_ING || !bus.ing_vld) begin
            starve_d = '0;
        end
    end

    // Registered issue stage and starvation counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_vld_q <= 1'b0;
            iss_q     <= '0;
            starve_q  <= '0;
        end else begin
            iss_vld_q <= iss_vld_d;
            iss_q     <= iss_d;
            starve_q  <= starve_d;
        end
    end

endmodule

// File: tb/tb_ob_cn_issue_arb.sv
// Directed bench for ob_cn_issue_arb with a queue-based reference model checked every cycle.
module tb_ob_cn_issue_arb;
    import ob_pkg::*;

    localparam int D        = 4;
    localparam int STARVE_N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ob_cn_issue_arb_if #(.D(D)) bus();

    ob_cn_issue_arb #(.D(D), .STARVE_N(STARVE_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int mid   = 0;
    int iid   = 0;

    cmd_t issued[$];
    logic ing_pat[$];

    // Reference model state: FIFO contents, output stage, ingress wait count.
    cmd_t mq[$];
    logic m_vld    = 1'b0;
    cmd_t m_iss    = '0;
    int   m_starve = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk_m(input int n);
        cmd_t c;
        c       = '0;
        c.id    = 8'(64 + n);
        c.op    = 2'd1;
        c.price = 16'(1000 + n);
        c.qty   = 5'(n);
        return c;
    endfunction

    function automatic cmd_t mk_i(input int n);
        cmd_t c;
        c       = '0;
        c.id    = 8'(128 + n);
        c.side  = 1'b1;
        c.op    = 2'd2;
        c.price = 16'(2000 + n);
        c.qty   = 5'(n + 3);
        return c;
    endfunction

    // Model: does ingress get the output slot this cycle?
    function automatic logic model_take_i();
        logic en;
        en = !m_vld || bus.iss_accept;
        return en && bus.ing_vld && (mq.size() == 0 || m_starve == STARVE_N);
    endfunction

    always @(negedge rst) begin
        mq.delete();
        m_vld    = 1'b0;
        m_iss    = '0;
        m_starve = 0;
    end

    // Model step at each active edge from the inputs held across it.
    always @(posedge clk) begin
        logic en, ti, tf, iv;
        int   sz;
        if (!rst) begin
            mq.delete();
            m_vld    = 1'b0;
            m_iss    = '0;
            m_starve = 0;
        end else begin
            sz = mq.size();
            iv = bus.ing_vld;
            en = !m_vld || bus.iss_accept;
            ti = model_take_i();
            tf = en && sz > 0 && !ti;
            if (tf)      m_iss = mq.pop_front();
            else if (ti) m_iss = bus.ing_cmd;
            if (en) m_vld = tf || ti;
            if (tf && iv)      m_starve = (m_starve < STARVE_N) ? m_starve + 1 : m_starve;
            else if (ti || !iv) m_starve = 0;
            if (bus.mtr_vld_r && sz != D) mq.push_back(bus.mtr_r);
        end
    end

    // Record what the controller actually consumes.
    always @(posedge clk) begin
        if (rst && bus.iss_vld_r && bus.iss_accept) issued.push_back(bus.iss_r);
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("iss_vld_r", bus.iss_vld_r, m_vld);
        if (m_vld) chk("iss_r", bus.iss_r, m_iss);
        chk("fifo_cnt_r", bus.fifo_cnt_r, mq.size());
        chk("fifo_full_r", bus.fifo_full_r, mq.size() == D);
        chk("mtr_accept", bus.mtr_accept, mq.size() != D);
        chk("ing_accept", bus.ing_accept, rst && model_take_i());
    end

    task automatic upd();
        bus.mtr_r   = mk_m(mid);
        bus.ing_cmd = mk_i(iid);
    endtask

    // One clock; advances the command ids when the DUT took them.
    task automatic cyc();
        logic mt, it;
        #1;
        mt = bus.mtr_vld_r & bus.mtr_accept;
        it = bus.ing_vld & bus.ing_accept;
        ing_pat.push_back(it);
        @(posedge clk);
        #1;
        if (mt) mid++;
        if (it) iid++;
        upd();
    endtask

    task automatic chk_log(input string nm, input cmd_t exp[$]);
        chk({nm, "_len"}, issued.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk(nm, (i < issued.size()) ? issued[i] : '0, exp[i]);
    endtask

    initial begin
        cmd_t exp[$];
        bus.mtr_vld_r  = 1'b0;
        bus.ing_vld    = 1'b1;
        bus.iss_accept = 1'b0;
        upd();

        // Reset state, ingress presented during reset.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_iss_vld", bus.iss_vld_r, 1'b0);
        chk("rst_iss_r", bus.iss_r, 32'h0);
        chk("rst_cnt", bus.fifo_cnt_r, 0);
        chk("rst_full", bus.fifo_full_r, 1'b0);
        chk("rst_mtr_acc", bus.mtr_accept, 1'b1);
        chk("rst_ing_acc", bus.ing_accept, 1'b0);
        bus.ing_vld = 1'b0;
        rst = 1'b1;
        cyc();

        // Single matured command: issued two edges after push.
        mid = 60; upd();
        bus.mtr_vld_r = 1'b1; bus.iss_accept = 1'b1;
        #1 chk("t2_mtr_acc", bus.mtr_accept, 1'b1);
        cyc();
        bus.mtr_vld_r = 1'b0;
        #1 chk("t2_vld_t1", bus.iss_vld_r, 1'b0);
        chk("t2_cnt_t1", bus.fifo_cnt_r, 1);
        cyc();
        #1 chk("t2_vld_t2", bus.iss_vld_r, 1'b1);
        chk("t2_iss_t2", bus.iss_r, mk_m(60));
        cyc();
        #1 chk("t2_vld_t3", bus.iss_vld_r, 1'b0);

        // Fill to full behind a stalled output, hold, then drain in order.
        mid = 0; iid = 0; upd();
        bus.ing_vld = 1'b1; bus.iss_accept = 1'b0;
        #1 chk("t3_ing_acc", bus.ing_accept, 1'b1);
        cyc();
        bus.ing_vld = 1'b0; bus.mtr_vld_r = 1'b1;
        #1 chk("t3_iss_x", bus.iss_r, mk_i(0));
        repeat (4) cyc();
        #1 chk("t3_full", bus.fifo_full_r, 1'b1);
        chk("t3_mtr_acc", bus.mtr_accept, 1'b0);
        chk("t3_cnt", bus.fifo_cnt_r, 4);
        bus.ing_vld = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 chk("t4_hold_ing", bus.ing_accept, 1'b0);
            chk("t4_hold_iss", bus.iss_r, mk_i(0));
            chk("t4_hold_cnt", bus.fifo_cnt_r, 4);
            cyc();
        end
        bus.ing_vld = 1'b0;
        issued.delete();
        bus.iss_accept = 1'b1;
        #1 chk("t3_pop_full", bus.mtr_accept, 1'b0);
        cyc();
        #1 chk("t3_reopen", bus.mtr_accept, 1'b1);
        cyc();
        bus.mtr_vld_r = 1'b0;
        repeat (6) cyc();
        exp = {mk_i(0), mk_m(0), mk_m(1), mk_m(2), mk_m(3), mk_m(4)};
        chk_log("t3_order", exp);

        // Starvation bound with FIFO kept busy and ingress always pending.
        mid = 16; iid = 16; upd();
        bus.mtr_vld_r = 1'b1; bus.iss_accept = 1'b0;
        repeat (5) cyc();
        #1 chk("t5_fill", bus.fifo_cnt_r, 4);
        issued.delete(); ing_pat.delete();
        bus.ing_vld = 1'b1; bus.iss_accept = 1'b1;
        repeat (11) cyc();
        bus.ing_vld = 1'b0; bus.iss_accept = 1'b0; bus.mtr_vld_r = 1'b0;
        exp = {mk_m(16), mk_m(17), mk_m(18), mk_m(19), mk_m(20), mk_i(16),
               mk_m(21), mk_m(22), mk_m(23), mk_m(24), mk_i(17)};
        chk_log("t5_seq", exp);
        for (int k = 0; k < 11; k++)
            chk("t5_ing_pulse", ing_pat[k], (k == 4 || k == 9) ? 1'b1 : 1'b0);
        bus.iss_accept = 1'b1;
        repeat (8) cyc();

        // Push and pop together at occupancy 2 across pointer wrap.
        mid = 32; upd();
        bus.iss_accept = 1'b0; bus.mtr_vld_r = 1'b1;
        repeat (3) cyc();
        #1 chk("t6_occ_start", bus.fifo_cnt_r, 2);
        issued.delete();
        bus.iss_accept = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            #1 chk("t6_occ", bus.fifo_cnt_r, 2);
        end
        bus.mtr_vld_r = 1'b0;
        repeat (4) cyc();
        exp.delete();
        for (int k = 32; k <= 40; k++) exp.push_back(mk_m(k));
        chk_log("t6_order", exp);

        // Asynchronous reset mid-operation discards everything.
        mid = 48; upd();
        bus.iss_accept = 1'b0; bus.mtr_vld_r = 1'b1;
        repeat (4) cyc();
        #1 chk("t7_pre_cnt", bus.fifo_cnt_r, 3);
        chk("t7_pre_vld", bus.iss_vld_r, 1'b1);
        bus.ing_vld = 1'b1;
        #1 rst = 1'b0;
        #1 chk("t7_rst_vld", bus.iss_vld_r, 1'b0);
        chk("t7_rst_iss", bus.iss_r, 32'h0);
        chk("t7_rst_cnt", bus.fifo_cnt_r, 0);
        chk("t7_rst_full", bus.fifo_full_r, 1'b0);
        chk("t7_rst_mtr", bus.mtr_accept, 1'b1);
        chk("t7_rst_ing", bus.ing_accept, 1'b0);
        cyc(); cyc();
        bus.mtr_vld_r = 1'b0; bus.ing_vld = 1'b0;
        rst = 1'b1;
        issued.delete();
        bus.iss_accept = 1'b1;
        repeat (4) cyc();
        chk("t7_no_stale", issued.size(), 0);
        chk("t7_post_vld", bus.iss_vld_r, 1'b0);

        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
